// File: rtl/axil_sram_slave_pkg.sv
// axil_sram_slave_pkg: shared AXI-Lite widths, response codes, FSM state types
// and the address-window test used by the SRAM slave.
`ifndef AXI_ADDR_BUS
`define AXI_ADDR_BUS 32
`define AXI_DATA_BUS 32
`define AXI_WSTRB_BUS 4
`define AXI_RESP_BUS 2
`endif

package axil_sram_slave_pkg;
   localparam int AXI_ADDR_W  = `AXI_ADDR_BUS;
   localparam int AXI_DATA_W  = `AXI_DATA_BUS;
   localparam int AXI_WSTRB_W = `AXI_WSTRB_BUS;
   localparam int AXI_RESP_W  = `AXI_RESP_BUS;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

   // One extra bit keeps addresses below the base from wrapping into the window.
   function automatic logic in_window(input logic [AXI_ADDR_W-1:0] addr,
                                      input logic [AXI_ADDR_W-1:0] base,
                                      input int unsigned words);
      logic [AXI_ADDR_W:0] w_word_off;
      w_word_off = ({1'b0, addr} - {1'b0, base}) >> 2;
      return w_word_off < (AXI_ADDR_W+1)'(words);
   endfunction
endpackage

// File: rtl/axil_sram_slave_bank.sv
// sram_bank: word-wide storage with one synchronous read port and one
// byte-enabled synchronous write port; contents are never reset.
module sram_bank
   import axil_sram_slave_pkg::*;
#(
   parameter int WORDS = 4096,
   parameter int IW    = $clog2(WORDS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_rd_en,
   input  logic [IW-1:0]          i_rd_idx,
   output logic [AXI_DATA_W-1:0]  o_rd_data,
   input  logic                   i_wr_en,
   input  logic [IW-1:0]          i_wr_idx,
   input  logic [AXI_DATA_W-1:0]  i_wr_data,
   input  logic [AXI_WSTRB_W-1:0] i_wr_strb
);
   logic [AXI_DATA_W-1:0] r_mem [WORDS];
   logic [AXI_DATA_W-1:0] r_q;

   assign o_rd_data = r_q;

   always_ff @(posedge clk)
      for (int b = 0; b < AXI_WSTRB_W; b++)
         if (i_wr_en && i_wr_strb[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];

   // Read register samples the array before any same-edge write lands.
   always_ff @(posedge clk or posedge rst)
      if (rst) r_q <= '0;
      else if (i_rd_en) r_q <= r_mem[i_rd_idx];
endmodule

// File: rtl/axil_sram_slave.sv
// axil_sram_slave: AXI4-Lite slave fronting an SRAM window, with independent
// read and write FSMs and programmable response latencies.
module axil_sram_slave
   import axil_sram_slave_pkg::*;
#(
   parameter logic [AXI_ADDR_W-1:0] ADDR_BASE  = 32'h8000_0000,
   parameter int                    MEM_WORDS  = 4096,
   parameter int                    RD_LATENCY = 1,
   parameter int                    WR_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [AXI_ADDR_W-1:0]  araddr,
   input  logic                   arvalid,
   output logic                   arready,
   output logic [AXI_DATA_W-1:0]  rdata,
   output logic [AXI_RESP_W-1:0]  rresp,
   output logic                   rvalid,
   input  logic                   rready,
   input  logic [AXI_ADDR_W-1:0]  awaddr,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [AXI_DATA_W-1:0]  wdata,
   input  logic [AXI_WSTRB_W-1:0] wstrb,
   input  logic                   wvalid,
   output logic                   wready,
   output logic [AXI_RESP_W-1:0]  bresp,
   output logic                   bvalid,
   input  logic                   bready
);
   localparam int         IW      = $clog2(MEM_WORDS);
   localparam logic [3:0] RD_LOAD = 4'(RD_LATENCY - 1);
   localparam logic [3:0] WR_LOAD = 4'(WR_LATENCY - 1);

   rd_state_t             r_rstate, w_rstate_nx;
   logic [3:0]            r_rcnt, w_rcnt_nx;
   logic [AXI_ADDR_W-1:0] r_araddr, w_raddr, w_roff;
   logic [AXI_RESP_W-1:0] r_rresp;
   logic [AXI_DATA_W-1:0] w_rq;
   logic                  w_rcap, w_rok;

   wr_state_t              r_wstate, w_wstate_nx;
   logic [3:0]             r_wcnt, w_wcnt_nx;
   logic [AXI_ADDR_W-1:0]  r_awaddr, w_waddr, w_woff;
   logic [AXI_DATA_W-1:0]  r_wdata, w_wdata;
   logic [AXI_WSTRB_W-1:0] r_wstrb, w_wstrb;
   logic [AXI_RESP_W-1:0]  r_bresp;
   logic                   r_awready, r_wready;
   logic                   w_aw_hs, w_w_hs, w_wcommit, w_wok;
   logic                   w_unused;

   assign arready = r_rstate == R_IDLE;
   assign rvalid  = r_rstate == R_RESP;
   assign rresp   = r_rresp;
   assign rdata   = r_rresp == RESP_OKAY ? w_rq : '0;
   // With RD_LATENCY = 1 the capture happens in the AR cycle itself.
   assign w_raddr = arready ? araddr : r_araddr;
   assign w_roff  = w_raddr - ADDR_BASE;
   assign w_rok   = in_window(w_raddr, ADDR_BASE, MEM_WORDS);

   always_comb begin
      w_rstate_nx = r_rstate;
      w_rcnt_nx   = r_rcnt;
      w_rcap      = 1'b0;
      case (r_rstate)
         R_IDLE: if (arvalid) begin
            w_rcnt_nx   = RD_LOAD;
            w_rcap      = RD_LATENCY == 1;
            w_rstate_nx = RD_LATENCY == 1 ? R_RESP : R_WAIT;
         end
         R_WAIT: begin
            w_rcap      = r_rcnt == 4'd1;
            w_rcnt_nx   = r_rcnt - 4'd1;
            w_rstate_nx = w_rcap ? R_RESP : R_WAIT;
         end
         R_RESP:  if (rready) w_rstate_nx = R_IDLE;
         default: w_rstate_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_rstate <= R_IDLE;
         r_rcnt   <= '0;
         r_araddr <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         r_rstate <= w_rstate_nx;
         r_rcnt   <= w_rcnt_nx;
         if (arvalid && arready) r_araddr <= araddr;
         if (w_rcap) r_rresp <= w_rok ? RESP_OKAY : RESP_DECERR;
      end

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_wstate == W_RESP;
   assign bresp   = r_bresp;
   assign w_aw_hs = awvalid & r_awready;
   assign w_w_hs  = wvalid & r_wready;
   // A handshake in the commit cycle has not been latched yet, so forward it.
   assign w_waddr = w_aw_hs ? awaddr : r_awaddr;
   assign w_wdata = w_w_hs ? wdata : r_wdata;
   assign w_wstrb = w_w_hs ? wstrb : r_wstrb;
   assign w_woff  = w_waddr - ADDR_BASE;
   assign w_wok   = in_window(w_waddr, ADDR_BASE, MEM_WORDS);

   always_comb begin
      w_wstate_nx = r_wstate;
      w_wcnt_nx   = r_wcnt;
      w_wcommit   = 1'b0;
      case (r_wstate)
         W_IDLE: if ((w_aw_hs || !r_awready) && (w_w_hs || !r_wready)) begin
            w_wcnt_nx   = WR_LOAD;
            w_wcommit   = WR_LATENCY == 1;
            w_wstate_nx = WR_LATENCY == 1 ? W_RESP : W_WAIT;
         end
         W_WAIT: begin
            w_wcommit   = r_wcnt == 4'd1;
            w_wcnt_nx   = r_wcnt - 4'd1;
            w_wstate_nx = w_wcommit ? W_RESP : W_WAIT;
         end
         W_RESP:  if (bready) w_wstate_nx = W_IDLE;
         default: w_wstate_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wstate  <= W_IDLE;
         r_wcnt    <= '0;
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else begin
         r_wstate <= w_wstate_nx;
         r_wcnt   <= w_wcnt_nx;
         if (w_aw_hs) r_awaddr <= awaddr;
         if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
         end
         if (r_wstate == W_RESP && bready) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
         end else begin
            if (w_aw_hs) r_awready <= 1'b0;
            if (w_w_hs) r_wready <= 1'b0;
         end
         if (w_wcommit) r_bresp <= w_wok ? RESP_OKAY : RESP_DECERR;
      end

   sram_bank #(.WORDS(MEM_WORDS)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_rd_en   (w_rcap & w_rok),
      .i_rd_idx  (w_roff[IW+1:2]),
      .o_rd_data (w_rq),
      .i_wr_en   (w_wcommit & w_wok),
      .i_wr_idx  (w_woff[IW+1:2]),
      .i_wr_data (w_wdata),
      .i_wr_strb (w_wstrb)
   );

   assign w_unused = ^{w_roff[1:0], w_roff[AXI_ADDR_W-1:IW+2], w_woff[1:0], w_woff[AXI_ADDR_W-1:IW+2]};
endmodule

// File: tb/tb_axil_sram_slave.sv
// tb_axil_sram_slave: scoreboard bench for axil_sram_slave with RD_LATENCY=3,
// WR_LATENCY=2; expected responses are queued at stimulus and popped on output.
module tb_axil_sram_slave;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          WORDS  = 4096;
   localparam int          RD_LAT = 3;
   localparam int          WR_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
   logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic [3:0]  wstrb = '0;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   int          checks = 0;
   int          passed = 0;
   int          cyc = 0;
   logic [33:0] rd_q[$];
   logic [1:0]  b_q[$];
   logic [31:0] model[int];

   axil_sram_slave #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit in_win(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      return off >= 0 && off < longint'(4 * WORDS);
   endfunction

   function automatic logic [33:0] exp_rd(input logic [31:0] a);
      int i;
      if (!in_win(a)) return {2'b11, 32'h0};
      i = int'((a - BASE) >> 2);
      return {2'b00, model.exists(i) ? model[i] : 32'h0};
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      logic [31:0] w;
      if (!in_win(a)) return;
      i = int'((a - BASE) >> 2);
      w = model.exists(i) ? model[i] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[i] = w;
   endfunction

   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int lead);
      int aw_t, w_t, t, h, n;
      bit aw_done, w_done, hs_aw, hs_w;
      logic [1:0] e;
      aw_t = lead > 0 ? lead : 0;
      w_t = lead < 0 ? -lead : 0;
      aw_done = 0; w_done = 0; t = 0;
      b_q.push_back(in_win(addr) ? 2'b00 : 2'b11);
      model_write(addr, data, strb);
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && t < 40) begin
         awvalid = !aw_done && t >= aw_t;
         wvalid = !w_done && t >= w_t;
         hs_aw = awvalid && awready;
         hs_w = wvalid && wready;
         @(posedge clk); #1;
         t++;
         aw_done |= hs_aw;
         w_done |= hs_w;
         if (aw_done != w_done) begin
            checks++;
            if ({awready, wready} !== {!aw_done, !w_done}) $display("FAIL ready_split aw=%b w=%b need %b%b", awready, wready, !aw_done, !w_done);
            else passed++;
         end
      end
      awvalid = 0; wvalid = 0;
      h = cyc; n = 0;
      while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (cyc - h + 1 !== WR_LAT) $display("FAIL b_latency got %0d need %0d", cyc - h + 1, WR_LAT);
      else passed++;
      e = b_q.pop_front();
      checks++;
      if (bresp !== e) $display("FAIL bresp addr=%h got %b need %b", addr, bresp, e);
      else passed++;
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      checks++;
      if ({bvalid, awready, wready} !== 3'b011) $display("FAIL b_done got %b need 011", {bvalid, awready, wready});
      else passed++;
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold);
      int h, n;
      logic [33:0] e;
      rd_q.push_back(exp_rd(addr));
      araddr = addr; arvalid = 1; n = 0;
      while (!arready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      h = cyc; arvalid = 0;
      checks++;
      if (arready !== 1'b0) $display("FAIL ar_blocked got %b need 0", arready);
      else passed++;
      n = 0;
      while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (cyc - h + 1 !== RD_LAT) $display("FAIL r_latency got %0d need %0d", cyc - h + 1, RD_LAT);
      else passed++;
      e = rd_q.pop_front();
      checks++;
      if ({rresp, rdata} !== e) $display("FAIL rdata addr=%h got %b/%h need %b/%h", addr, rresp, rdata, e[33:32], e[31:0]);
      else passed++;
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk); #1; end
         checks++;
         if ({rvalid, rresp, rdata} !== {1'b1, e}) $display("FAIL r_hold got %b/%b/%h need 1/%b/%h", rvalid, rresp, rdata, e[33:32], e[31:0]);
         else passed++;
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      checks++;
      if ({rvalid, arready} !== 2'b01) $display("FAIL r_done got %b need 01", {rvalid, arready});
      else passed++;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) $display("FAIL reset_flags got %b need 11100", {arready, awready, wready, rvalid, bvalid});
      else passed++;
      checks++;
      if (rdata !== 32'h0) $display("FAIL reset_rdata got %h need 0", rdata);
      else passed++;
      checks++;
      if ({rresp, bresp} !== 4'b0000) $display("FAIL reset_resp got %b need 0000", {rresp, bresp});
      else passed++;
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_read_latency;
      do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
      do_read(BASE + 32'h10, 2);
   endtask

   task automatic test_w_before_aw;
      do_write(BASE + 32'h4, 32'h1122_3344, 4'hF, -1);
      do_write(BASE + 32'h4, 32'h0000_00AB, 4'b0001, 2);
      do_read(BASE + 32'h4, 0);
   endtask

   task automatic test_back_to_back;
      do_write(BASE + 32'h3FFC, 32'hA5A5_0F0F, 4'hF, 0);
      do_write(BASE + 32'h8, 32'h7788_99AA, 4'hF, -2);
      do_write(BASE + 32'h8, 32'h1234_5678, 4'b1010, 1);
      do_read(BASE + 32'h3FFC, 0);
      do_read(BASE + 32'h8, 1);
   endtask

   task automatic test_strobe_zero;
      do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'b0000, 0);
      do_read(BASE + 32'h8, 0);
   endtask

   task automatic test_decerr;
      do_write(BASE, 32'h0BAD_F00D, 4'hF, 0);
      do_read(32'h7FFF_FFFC, 0);
      do_write(BASE + 32'h4000, 32'hCAFE_CAFE, 4'hF, 0);
      do_read(BASE + 32'h4000, 0);
      do_read(BASE, 0);
   endtask

   task automatic test_collision;
      logic [33:0] e;
      logic [1:0]  eb;
      rd_q.push_back(exp_rd(BASE));
      b_q.push_back(2'b00);
      model_write(BASE, 32'hFFFF_FFFF, 4'hF);
      rready = 1; bready = 1;
      araddr = BASE; arvalid = 1;
      @(posedge clk); #1;
      arvalid = 0;
      awaddr = BASE; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      @(posedge clk); #1;
      checks++;
      if ({rvalid, bvalid} !== 2'b11) $display("FAIL collide_valid got %b need 11", {rvalid, bvalid});
      else passed++;
      e = rd_q.pop_front();
      checks++;
      if ({rresp, rdata} !== e) $display("FAIL collide_rdata got %b/%h need %b/%h", rresp, rdata, e[33:32], e[31:0]);
      else passed++;
      eb = b_q.pop_front();
      checks++;
      if (bresp !== eb) $display("FAIL collide_bresp got %b need %b", bresp, eb);
      else passed++;
      @(posedge clk); #1;
      rready = 0; bready = 0;
      checks++;
      if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) $display("FAIL collide_done got %b need 00111", {rvalid, bvalid, arready, awready, wready});
      else passed++;
      do_read(BASE, 0);
   endtask

   task automatic test_reset_mid_write;
      do_write(BASE + 32'h20, 32'h1234_5678, 4'hF, 0);
      awaddr = BASE + 32'h20; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      checks++;
      if ({awready, wready, bvalid} !== 3'b000) $display("FAIL wwait_flags got %b need 000", {awready, wready, bvalid});
      else passed++;
      #1 rst = 1;
      #2;
      checks++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) $display("FAIL midrst_flags got %b need 11100", {arready, awready, wready, rvalid, bvalid});
      else passed++;
      rst = 0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if ({bvalid, awready, wready} !== 3'b011) $display("FAIL postrst_flags got %b need 011", {bvalid, awready, wready});
      else passed++;
      do_read(BASE + 32'h20, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_latency();
      test_w_before_aw();
      test_back_to_back();
      test_strobe_zero();
      test_decerr();
      test_collision();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
